// File: rtl/bcd_ud_counter_n.sv
// bcd_ud_counter_n: DIGITS-decade BCD up/down counter for game clocks (shot clock,
// game clock digits, period counters). Driven by the tick generator on CEP and read
// by the 7-segment decoders on Q.
//
// Parameters:
//   DIGITS  number of BCD decades (1..6); Q and D are 4*DIGITS wide
//   WRAP    0 = saturate at terminal count, 1 = wrap (0..0 <-> 9..9)
//
// Ports:
//   CP    clock, rising edge
//   CR    asynchronous active-low reset (clears Q, DONE, ERR)
//   CEP   count enable (tick)
//   CET   count enable (run/pause); also gates TC
//   PE    synchronous active-low parallel load, takes priority over counting
//   UD    direction, 1 = up, 0 = down
//   D     load value, digit k at D[4k+3:4k], digit 0 least significant
//   Q     current BCD count
//   TC    combinational terminal count: CET & (UD ? all nines : all zeros)
//   DONE  registered one-cycle pulse when a count step lands on terminal
//   ERR   sticky flag: last load was rejected because a digit of D exceeded 9
module bcd_ud_counter_n #(
  parameter int unsigned DIGITS = 2,
  parameter bit          WRAP   = 1'b0
) (
  input  logic                CP,
  input  logic                CR,
  input  logic                CEP,
  input  logic                CET,
  input  logic                PE,
  input  logic                UD,
  input  logic [4*DIGITS-1:0] D,
  output logic [4*DIGITS-1:0] Q,
  output logic                TC,
  output logic                DONE,
  output logic                ERR
);

  localparam int unsigned W = 4 * DIGITS;

  logic [W-1:0] q_q, q_d;
  logic         done_q, done_d;
  logic         err_q, err_d;

  logic [W-1:0] step_val;
  logic         step_is_term;
  logic         all_zero, all_nine, at_term, d_valid;
  logic         ripple;
  logic [3:0]   dig, nd;

  // Whole-word flags on the current count and on the load value.
  always_comb begin
    all_zero = 1'b1;
    all_nine = 1'b1;
    d_valid  = 1'b1;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (q_q[4*k +: 4] != 4'd0) all_zero = 1'b0;
      if (q_q[4*k +: 4] != 4'd9) all_nine = 1'b0;
      if (D[4*k +: 4] > 4'd9)    d_valid  = 1'b0;
    end
  end

  assign at_term = UD ? all_nine : all_zero;

  // One BCD step with a carry/borrow ripple from digit 0 upward. Running off the top
  // decade naturally yields the wrapped value (0..0 -> 9..9 down, 9..9 -> 0..0 up).
  always_comb begin
    step_val     = q_q;
    step_is_term = 1'b1;
    ripple       = 1'b1;
    dig          = 4'd0;
    nd           = 4'd0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      dig = q_q[4*k +: 4];
      nd  = dig;
      if (ripple) begin
        if (UD) begin
          if (dig >= 4'd9) begin
            nd = 4'd0;
          end else begin
            nd     = dig + 4'd1;
            ripple = 1'b0;
          end
        end else begin
          if (dig == 4'd0) begin
            nd = 4'd9;
          end else begin
            nd     = dig - 4'd1;
            ripple = 1'b0;
          end
        end
      end
      step_val[4*k +: 4] = nd;
      if (nd != (UD ? 4'd9 : 4'd0)) step_is_term = 1'b0;
    end
  end

  always_comb begin
    q_d    = q_q;
    err_d  = err_q;
    done_d = 1'b0;
    if (!PE) begin
      // Reject the whole word if any digit is out of range.
      if (d_valid) begin
        q_d   = D;
        err_d = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end else if (CEP && CET) begin
      if (!at_term || WRAP) q_d = step_val;
      // Only arriving at terminal pulses; parking there or wrapping away does not.
      done_d = !at_term && step_is_term;
    end
  end

  always_ff @(posedge CP or negedge CR) begin
    if (!CR) begin
      q_q    <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      q_q    <= q_d;
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

  assign Q    = q_q;
  assign DONE = done_q;
  assign ERR  = err_q;
  assign TC   = CET && at_term;

endmodule
